// File: rtl/params_pkg.sv
// Shared parameters and the frame scheduler state type for the convolution datapath.
package params_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int COEFF_COUNT = 16;

   typedef enum logic [1:0] {
      SCHED_IDLE   = 2'd0,
      SCHED_FLUSH  = 2'd1,
      SCHED_STREAM = 2'd2,
      SCHED_DRAIN  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first active request at or after ptr wins, grant is one-hot.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         for (int j = 0; j < N; j++) begin
            if (j == idx && !found && req[j]) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/conv_frame_scheduler.sv
// Shares one convolution core among NUM_REQ frame requesters: each frame is preceded by a
// zero flush, and the matching flush results are discarded before results are forwarded.
//
// state  | meaning
// IDLE   | waiting for a request; grants, and zero-length frames complete here
// FLUSH  | pushing FLUSH_LEN zeros to clear the core taps
// STREAM | granted requester wired straight to the core input
// DRAIN  | all inputs pushed, forwarding remaining results until m_last
module conv_frame_scheduler
   import params_pkg::*;
#(
   parameter int  NUM_REQ   = 2,
   parameter int  LEN_W     = 12,
   parameter int  FLUSH_LEN = COEFF_COUNT - 1,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*LEN_W-1:0]      req_len,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            s_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
   output logic [NUM_REQ-1:0]            s_ready,
   output logic                          core_in_valid,
   input  logic                          core_in_ready,
   output logic [DATA_WIDTH-1:0]         core_in_data,
   input  logic                          core_out_valid,
   input  logic [DATA_WIDTH-1:0]         core_out_data,
   output logic                          core_out_ready,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic [ID_W-1:0]               m_id,
   output logic                          m_last,
   output logic                          busy,
   output logic                          frame_done,
   output logic [ID_W-1:0]               done_id
);

   sched_state_t    state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, gid_q, gid_d, done_id_q, done_id_d;
   logic [LEN_W-1:0] len_q, len_d, in_rem_q, in_rem_d;
   logic [LEN_W-1:0] disc_rem_q, disc_rem_d, fwd_rem_q, fwd_rem_d;
   logic            frame_done_q, frame_done_d;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [ID_W-1:0]       arb_id;
   logic [LEN_W-1:0]      arb_len;
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  last_hs;

   rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_gnt)
   );

   always_comb begin
      arb_id    = '0;
      arb_len   = '0;
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            arb_id  = ID_W'(i);
            arb_len = req_len[i*LEN_W +: LEN_W];
         end
         if (ID_W'(i) == gid_q) begin
            sel_valid = s_valid[i];
            sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      gid_d          = gid_q;
      len_d          = len_q;
      in_rem_d       = in_rem_q;
      disc_rem_d     = disc_rem_q;
      fwd_rem_d      = fwd_rem_q;
      frame_done_d   = 1'b0;
      done_id_d      = done_id_q;
      last_hs        = 1'b0;
      req_ready      = '0;
      s_ready        = '0;
      core_in_valid  = 1'b0;
      core_in_data   = '0;
      core_out_ready = 1'b1;
      m_valid        = 1'b0;
      m_last         = 1'b0;

      // Result side runs in every busy state since core outputs overlap core inputs.
      if (state_q != SCHED_IDLE) begin
         if (disc_rem_q != '0) begin
            if (core_out_valid) disc_rem_d = disc_rem_q - LEN_W'(1);
         end else if (fwd_rem_q != '0) begin
            m_valid        = core_out_valid;
            core_out_ready = m_ready;
            m_last         = (fwd_rem_q == LEN_W'(1));
            if (core_out_valid && m_ready) begin
               fwd_rem_d = fwd_rem_q - LEN_W'(1);
               last_hs   = (fwd_rem_q == LEN_W'(1));
            end
         end
      end

      case (state_q)
         SCHED_IDLE: begin
            if (req_valid != '0) begin
               req_ready = arb_gnt;
               gid_d     = arb_id;
               len_d     = arb_len;
               ptr_d     = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + ID_W'(1);
               if (arb_len == '0) begin
                  frame_done_d = 1'b1;
                  done_id_d    = arb_id;
               end else begin
                  disc_rem_d = LEN_W'(FLUSH_LEN);
                  fwd_rem_d  = arb_len;
                  if (FLUSH_LEN == 0) begin
                     in_rem_d = arb_len;
                     state_d  = SCHED_STREAM;
                  end else begin
                     in_rem_d = LEN_W'(FLUSH_LEN);
                     state_d  = SCHED_FLUSH;
                  end
               end
            end
         end
         SCHED_FLUSH: begin
            core_in_valid = 1'b1;
            if (core_in_ready) begin
               if (in_rem_q <= LEN_W'(1)) begin
                  in_rem_d = len_q;
                  state_d  = SCHED_STREAM;
               end else begin
                  in_rem_d = in_rem_q - LEN_W'(1);
               end
            end
         end
         SCHED_STREAM: begin
            core_in_valid = sel_valid;
            core_in_data  = sel_data;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (ID_W'(i) == gid_q) s_ready[i] = core_in_ready;
            end
            if (sel_valid && core_in_ready) begin
               if (in_rem_q <= LEN_W'(1)) begin
                  in_rem_d = '0;
                  state_d  = SCHED_DRAIN;
               end else begin
                  in_rem_d = in_rem_q - LEN_W'(1);
               end
            end
         end
         SCHED_DRAIN: begin
            if (last_hs || fwd_rem_q == '0) begin
               state_d      = SCHED_IDLE;
               frame_done_d = 1'b1;
               done_id_d    = gid_q;
            end
         end
         default: state_d = SCHED_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SCHED_IDLE;
         ptr_q        <= '0;
         gid_q        <= '0;
         len_q        <= '0;
         in_rem_q     <= '0;
         disc_rem_q   <= '0;
         fwd_rem_q    <= '0;
         frame_done_q <= 1'b0;
         done_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gid_q        <= gid_d;
         len_q        <= len_d;
         in_rem_q     <= in_rem_d;
         disc_rem_q   <= disc_rem_d;
         fwd_rem_q    <= fwd_rem_d;
         frame_done_q <= frame_done_d;
         done_id_q    <= done_id_d;
      end
   end

   assign m_data     = core_out_data;
   assign m_id       = gid_q;
   assign busy       = (state_q != SCHED_IDLE);
   assign frame_done = frame_done_q;
   assign done_id    = done_id_q;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: queue-based core model, sample feeders and a result scoreboard.
module tb_conv_frame_scheduler;
   import params_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int LEN_W   = 12;
   localparam int DW      = DATA_WIDTH;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } src_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          id;
      logic          last;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       s_valid = '0;
   logic [NUM_REQ*DW-1:0]    s_data = '0;
   logic [NUM_REQ-1:0]       s_ready;
   logic                     core_in_valid;
   logic                     core_in_ready;
   logic [DW-1:0]            core_in_data;
   logic                     core_out_valid = 1'b0;
   logic [DW-1:0]            core_out_data = '0;
   logic                     core_out_ready;
   logic                     m_valid;
   logic                     m_ready;
   logic [DW-1:0]            m_data;
   logic [0:0]               m_id;
   logic                     m_last;
   logic                     busy;
   logic                     frame_done;
   logic [0:0]               done_id;

   int checks = 0, errors = 0;
   int grant_cnt = 0, done_cnt = 0, m_beats = 0, s_hs_cnt = 0;
   int zero_cnt = 0, samp_in_cnt = 0, cin_cycles = 0;
   bit rand_mr = 1'b0;
   bit pend = 1'b0;
   logic pend_id = 1'b0;
   int grant_log[$];
   src_t src0_q[$], src1_q[$];
   exp_t exp_q[$];
   logic [DW-1:0] core_q[$];

   conv_frame_scheduler dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
      .core_out_valid(core_out_valid), .core_out_data(core_out_data), .core_out_ready(core_out_ready),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last),
      .busy(busy), .frame_done(frame_done), .done_id(done_id)
   );

   always #5 clk = ~clk;

   // Core model: one-cycle pass-through FIFO with no reset, like a tap line.
   always @(posedge clk) begin
      if (core_in_valid && core_in_ready) core_q.push_back(core_in_data);
      if (core_out_valid && core_out_ready && core_q.size() > 0) void'(core_q.pop_front());
      core_out_valid <= (core_q.size() > 0);
      core_out_data  <= (core_q.size() > 0) ? core_q[0] : '0;
   end

   // Sample feeders; accepted samples become scoreboard entries.
   always @(posedge clk) begin
      src_t s;
      if (s_valid[0] && s_ready[0] && src0_q.size() > 0) begin
         s = src0_q.pop_front();
         exp_q.push_back('{s.data, 1'b0, s.last});
         s_hs_cnt++;
      end
      if (s_valid[1] && s_ready[1] && src1_q.size() > 0) begin
         s = src1_q.pop_front();
         exp_q.push_back('{s.data, 1'b1, s.last});
         s_hs_cnt++;
      end
      s_valid <= {src1_q.size() > 0, src0_q.size() > 0};
      s_data  <= {(src1_q.size() > 0) ? src1_q[0].data : DW'(0),
                  (src0_q.size() > 0) ? src0_q[0].data : DW'(0)};
   end

   always @(posedge clk) begin
      if (rand_mr) begin
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   nxt_pend;
      logic nxt_id;
      int   gi;
      nxt_pend = 1'b0;
      nxt_id   = 1'b0;
      if (req_ready != '0) begin
         gi = req_ready[1] ? 1 : 0;
         checks++;
         if (!$onehot(req_ready) || busy !== 1'b0) begin
            errors++;
            $display("FAIL grant_onehot: req_ready=%b busy=%b, required one-hot while idle", req_ready, busy);
         end
         grant_log.push_back(gi);
         grant_cnt++;
         if (req_len[gi*LEN_W +: LEN_W] == '0) begin
            nxt_pend = 1'b1;
            nxt_id   = 1'(gi);
         end
      end
      if (core_in_valid === 1'b1 && core_in_ready) begin
         if (core_in_data == '0) zero_cnt++;
         else samp_in_cnt++;
      end
      if (core_in_valid === 1'b1) cin_cycles++;
      if (m_valid === 1'b1 && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: m_data=%0d m_id=%0d, required no beat", m_data, m_id);
         end else begin
            e = exp_q.pop_front();
            m_beats++;
            if (m_data !== e.data || m_id !== e.id || m_last !== e.last) begin
               errors++;
               $display("FAIL result: data=%0d id=%0d last=%b, required data=%0d id=%0d last=%b",
                        m_data, m_id, m_last, e.data, e.id, e.last);
            end
            if (e.last) begin
               nxt_pend = 1'b1;
               nxt_id   = e.id;
            end
         end
      end
      if (frame_done === 1'b1 || pend) begin
         checks++;
         if (frame_done !== pend || (pend && done_id !== pend_id)) begin
            errors++;
            $display("FAIL frame_done: done=%b id=%0d, required done=%b id=%0d", frame_done, done_id, pend, pend_id);
         end
         if (frame_done === 1'b1) done_cnt++;
      end
      pend    = nxt_pend && !rst;
      pend_id = nxt_id;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_src(input int id, input int len, input int base, input int step);
      src_t s;
      for (int i = 0; i < len; i++) begin
         s.data = DW'(base + i * step);
         s.last = (i == len - 1);
         if (id == 0) src0_q.push_back(s);
         else src1_q.push_back(s);
      end
   endtask

   task automatic grant_req(input int id, input int len);
      int g0, n;
      req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
      req_valid[id] = 1'b1;
      g0 = grant_cnt;
      n  = 0;
      while (grant_cnt == g0 && n < 100) begin
         tick();
         n++;
      end
      req_valid[id] = 1'b0;
      checks++;
      if (grant_cnt == g0 || grant_log[$] != id) begin
         errors++;
         $display("FAIL grant_req: grants=%0d last=%0d, required a grant to %0d", grant_cnt - g0,
                  (grant_log.size() > 0) ? grant_log[$] : -1, id);
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done_cnt < target) begin
         errors++;
         $display("FAIL done_timeout: frame_done count=%0d, required %0d", done_cnt, target);
      end
   endtask

   task automatic test_reset();
      int g0;
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({busy, frame_done, req_ready, s_ready, core_in_valid, m_valid, m_last, core_out_ready} !== 10'b00_0000_0001) begin
         errors++;
         $display("FAIL reset_values: busy=%b done=%b req_ready=%b s_ready=%b cin_v=%b m_v=%b m_last=%b cout_r=%b, required all 0 and cout_r=1",
                  busy, frame_done, req_ready, s_ready, core_in_valid, m_valid, m_last, core_out_ready);
      end
      tick();
      rst = 1'b0;
      // both requesting zero-length frames: pointer after reset must favour index 0
      g0 = done_cnt;
      req_len   = '0;
      req_valid = 2'b11;
      while (grant_cnt == 0) tick();
      req_valid = 2'b00;
      checks++;
      if (grant_log[0] != 0) begin
         errors++;
         $display("FAIL reset_ptr: first grant=%0d, required 0", grant_log[0]);
      end
      wait_done(g0 + 1, 5);
   endtask

   task automatic test_single_frame();
      int d0, b0;
      d0 = done_cnt;
      b0 = m_beats;
      zero_cnt    = 0;
      samp_in_cnt = 0;
      load_src(0, 4, 64, 0);
      grant_req(0, 4);
      wait_done(d0 + 1, 200);
      checks++;
      if (zero_cnt != 15 || samp_in_cnt != 4 || m_beats - b0 != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_frame: zeros=%0d samples=%0d beats=%0d left=%0d, required 15 4 4 0",
                  zero_cnt, samp_in_cnt, m_beats - b0, exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      int g0, d0, b0, n;
      pulse_reset();
      g0 = grant_cnt;
      d0 = done_cnt;
      b0 = m_beats;
      load_src(0, 3, 'h100, 1);
      load_src(0, 3, 'h110, 1);
      load_src(1, 3, 'h200, 1);
      load_src(1, 3, 'h210, 1);
      req_len   = {LEN_W'(3), LEN_W'(3)};
      req_valid = 2'b11;
      n = 0;
      while (grant_cnt - g0 < 4 && n < 500) begin
         tick();
         n++;
      end
      req_valid = 2'b00;
      wait_done(d0 + 4, 300);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (grant_log.size() < g0 + 4 || grant_log[g0 + k] != (k % 2)) begin
            errors++;
            $display("FAIL rr_order: grant %0d=%0d, required %0d", k,
                     (grant_log.size() > g0 + k) ? grant_log[g0 + k] : -1, k % 2);
         end
      end
      checks++;
      if (m_beats - b0 != 12 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_beats: beats=%0d left=%0d, required 12 0", m_beats - b0, exp_q.size());
      end
   endtask

   task automatic test_zero_len();
      int c0, d0;
      c0 = cin_cycles;
      d0 = done_cnt;
      grant_req(1, 0);
      repeat (4) tick();
      checks++;
      if (cin_cycles != c0 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL zero_len: cin_valid cycles=%0d dones=%0d, required 0 1", cin_cycles - c0, done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int d0, b0;
      d0 = done_cnt;
      b0 = m_beats;
      load_src(0, 8, 'h300, 7);
      rand_mr = 1'b1;
      grant_req(0, 8);
      wait_done(d0 + 1, 400);
      rand_mr = 1'b0;
      tick();
      m_ready = 1'b1;
      checks++;
      if (m_beats - b0 != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL backpressure: beats=%0d left=%0d, required 8 0", m_beats - b0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0, h0, n, b0;
      d0 = done_cnt;
      h0 = s_hs_cnt;
      load_src(0, 10, 'h400, 3);
      grant_req(0, 10);
      n = 0;
      while (s_hs_cnt - h0 < 3 && n < 200) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      src0_q.delete();
      exp_q.delete();
      @(negedge clk);
      checks++;
      if ({busy, frame_done, req_ready, s_ready, core_in_valid, m_valid, m_last, core_out_ready} !== 10'b00_0000_0001) begin
         errors++;
         $display("FAIL midframe_reset: busy=%b done=%b req_ready=%b s_ready=%b cin_v=%b m_v=%b m_last=%b cout_r=%b, required all 0 and cout_r=1",
                  busy, frame_done, req_ready, s_ready, core_in_valid, m_valid, m_last, core_out_ready);
      end
      n = 0;
      while ((core_q.size() > 0 || core_out_valid) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (done_cnt != d0 || core_q.size() != 0) begin
         errors++;
         $display("FAIL midframe_abandon: dones=%0d core left=%0d, required 0 0", done_cnt - d0, core_q.size());
      end
      b0 = m_beats;
      load_src(0, 2, 'h500, 1);
      grant_req(0, 2);
      wait_done(d0 + 1, 200);
      checks++;
      if (m_beats - b0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset_frame: beats=%0d left=%0d, required 2 0", m_beats - b0, exp_q.size());
      end
   endtask

   task automatic test_flush_stall();
      int d0, b0;
      d0 = done_cnt;
      b0 = m_beats;
      zero_cnt    = 0;
      samp_in_cnt = 0;
      load_src(1, 3, 'h600, 5);
      grant_req(1, 3);
      repeat (4) tick();
      core_in_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || core_in_valid !== 1'b1 || core_in_data !== '0 || s_ready !== 2'b00) begin
         errors++;
         $display("FAIL flush_stall_hold: busy=%b cin_v=%b cin_d=%0d s_ready=%b, required 1 1 0 00",
                  busy, core_in_valid, core_in_data, s_ready);
      end
      repeat (2) tick();
      core_in_ready = 1'b1;
      wait_done(d0 + 1, 200);
      checks++;
      if (zero_cnt != 15 || samp_in_cnt != 3 || m_beats - b0 != 3) begin
         errors++;
         $display("FAIL flush_stall: zeros=%0d samples=%0d beats=%0d, required 15 3 3",
                  zero_cnt, samp_in_cnt, m_beats - b0);
      end
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = '0;
      req_len       = '0;
      core_in_ready = 1'b1;
      m_ready       = 1'b1;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_zero_len();
      test_backpressure();
      test_reset_mid_frame();
      test_flush_stall();
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_frame_scheduler.md
CONV_FRAME_SCHEDULER -- requirements
Module: conv_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of frame requesters sharing one algorithm_core.
REQ-002 SHALL have parameter LEN_W, default 12, frame-length field width in samples.
REQ-003 SHALL have parameter FLUSH_LEN, default COEFF_COUNT-1, zero samples pushed before each frame.
REQ-004 SHALL have one clock and a synchronous, active-high reset, listed as: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have the requester command ports: req_valid in NUM_REQ, per-requester frame request; req_len in NUM_REQ*LEN_W, frame length; req_ready out NUM_REQ, one-hot command accept.
REQ-006 SHALL have the requester sample ports: s_valid in NUM_REQ; s_data in NUM_REQ*DATA_WIDTH, signed samples; s_ready out NUM_REQ.
REQ-007 SHALL have the core-side ports: core_in_valid out 1; core_in_ready in 1; core_in_data out DATA_WIDTH; core_out_valid in 1; core_out_data in DATA_WIDTH; core_out_ready out 1.
REQ-008 SHALL have the result ports: m_valid out 1; m_ready in 1; m_data out DATA_WIDTH; m_id out $clog2(NUM_REQ); m_last out 1, final result of frame.
REQ-009 SHALL have the status ports: busy out 1, high in any state except IDLE; frame_done out 1, one-cycle pulse; done_id out $clog2(NUM_REQ).

Function
REQ-010 SHALL implement the FSM IDLE -> FLUSH -> STREAM -> DRAIN -> IDLE.
REQ-011 In IDLE, with any req_valid high, SHALL grant round-robin starting from the index after the last grant (index 0 after reset), assert req_ready for exactly one cycle to the winner, and latch its id and len.
REQ-012 A granted len==0 SHALL complete with no core traffic: frame_done pulses the cycle after the grant; the FSM stays in IDLE.
REQ-013 In FLUSH SHALL drive core_in_valid=1 and core_in_data=0 until FLUSH_LEN handshakes (core_in_valid & core_in_ready) have completed, then enter STREAM.
REQ-014 In STREAM SHALL combinationally connect the granted requester to the core: core_in_valid=s_valid[g], core_in_data=s_data[g], s_ready[g]=core_in_ready; all other s_ready=0; enter DRAIN after len handshakes.
REQ-015 Outside FLUSH and STREAM, core_in_valid and every s_ready SHALL be 0.
REQ-016 SHALL count core outputs per frame: the first FLUSH_LEN results are discarded with core_out_ready=1 and m_valid=0; the next len results are forwarded with m_valid=core_out_valid, m_data=core_out_data, m_id=g, and core_out_ready=m_ready.
REQ-017 m_last SHALL be 1 only on the len-th forwarded result.
REQ-018 The DRAIN->IDLE transition SHALL occur on the m_last handshake, with frame_done=1 and done_id=g in the following cycle.
REQ-019 Discard and forward counting SHALL also run during FLUSH and STREAM, because core outputs overlap core inputs.
REQ-020 No new grant SHALL occur before the frame_done cycle; the grant pointer updates to g+1 mod NUM_REQ at the grant.
REQ-021 req_len changes after grant SHALL have no effect.
REQ-022 Counters SHALL be LEN_W bits; len=2^LEN_W-1 SHALL be handled without wrap.
REQ-023 m_data SHALL pass through unchanged; no arithmetic on samples.

Reset
REQ-024 On rst (sampled at clk): state=IDLE, grant pointer=0, all counters=0; busy, frame_done, req_ready, s_ready, core_in_valid, m_valid and m_last = 0; core_out_ready=1, so stale core results are dropped.
REQ-025 Reset mid-frame SHALL abandon the frame with no frame_done; the next frame's FLUSH guarantees clean taps.

Structure
REQ-026 DATA_WIDTH, COEFF_COUNT and the new sched_state_t enum SHALL live in params_pkg.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).
REQ-028 The algorithm_core SHALL be instantiated by the parent, not inside this block.

Verification
REQ-029 Reset, then req_valid[0]=1, len=4, samples 64,64,64,64 with all readies high -> 15 zero pushes, then 4 samples to the core; exactly 4 m_valid beats with m_id=0 and m_last on the 4th; frame_done one cycle later.
REQ-030 req_valid=2'b11 held continuously -> grants alternate 0,1,0,1; no grant overlaps a busy frame.
REQ-031 Grant to req 1 with len=0 -> req_ready[1] pulse, frame_done with done_id=1 next cycle, core_in_valid never asserted.
REQ-032 m_ready toggled 1,0,0,1 randomly during a len=8 frame -> all 8 results delivered in order, none dropped or duplicated; discarded flush results never appear on m_valid.
REQ-033 rst asserted in STREAM after 3 of 10 samples -> all outputs at reset values next cycle; no frame_done; a new len=2 frame then completes correctly.
REQ-034 core_in_ready low for 5 cycles during FLUSH -> flush count resumes without skipping; exactly 15 zeros are pushed.
